p_bool_neuron_acc: RTL
======================

# p_bool_neuron_acc

Sequential accumulator and binary activation stage sitting directly downstream of the boolean popcount accumulator (`p_bool_acc`). It consumes one signed partial sum per beat (ones-minus-zeros of an IN-bit XNOR slice), saturating-accumulates the beats of one neuron frame, and compares the total against a threshold. It then presents a 1-bit activation plus the full sum to the next layer through a valid/ready handshake.

## Interface
- `IN`, 8: bits per upstream slice; partial sums lie in [-IN, +IN].
- `CONF`, `DEF_DCONF`: shared datapath configuration (`dconf_t`).
- `PREC`, `CONF.prec`: accumulator/sum width, signed two's complement.
- `BEATS`, 4: maximum beats per frame; `CW = $clog2(BEATS+1)`.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  partial-sum beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_sum`  in  PREC  signed partial sum (upstream `out`).
- `in_ovf` / `in_udf`  in  1 each  upstream overflow/underflow flags.
- `in_last`  in  1  final beat of frame.
- `thresh`  in  PREC  signed threshold; sampled with first beat of frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_act`  out  1  activation: 1 iff sum >= threshold.
- `out_sum`  out  PREC  saturated frame sum.
- `out_sat`  out  1  saturation occurred in frame (local or upstream).
- `out_err`  out  1  frame exceeded BEATS beats.
- `out_beats`  out  CW  beats accepted in frame.

## Operation
- States: IDLE (no beat yet), ACC (mid-frame), HOLD (result presented).
- `in_ready` = 1 in IDLE/ACC, 0 in HOLD. `out_valid` = 1 only in HOLD.
- Beat accepted when `in_valid & in_ready`.
- IDLE + beat: acc ← sat(0 + in_sum), thr ← `thresh`, beats ← 1, sat ← in_ovf|in_udf, err ← 0; go ACC, or HOLD if `in_last`.
- ACC + beat: acc ← sat(acc + in_sum); sat |= overflow|in_ovf|in_udf; beats increments, saturating at BEATS; err set if beat accepted when beats = BEATS; go HOLD if `in_last`.
- HOLD + `out_ready`: go IDLE; outputs hold their values until the handshake.
- Saturating add: compute in PREC+1 bits; clamp to 2^(PREC-1)-1 or -2^(PREC-1); clamp sets sat.
- `out_act` = (acc >= thr) signed compare, registered with the state transition into HOLD.
- `in_valid` with `in_ready` low is ignored (no side effects); upstream holds beat.
- `thresh` changes mid-frame are ignored.

## Timing
- Reset: state IDLE, acc 0, thr 0, beats 0, all flags 0; `out_valid` 0, `out_act` 0, `out_sum` 0, `in_ready` 1.
- Reset asserted mid-frame or in HOLD: the partial frame or result is discarded; IDLE next cycle.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle within a frame; one idle input cycle (HOLD) minimum per frame. First beat of next frame is accepted no earlier than the cycle after the output handshake.
- Single-beat frame (first beat with `in_last`): IDLE→HOLD directly.
- All outputs registered; no combinational in→out path except `in_ready`, which is derived from state only.

## Structure
- Shared `perceptron.svh` package: state enum `bacc_state_t` (IDLE/ACC/HOLD), saturation limit macros derived from PREC, and the existing `dconf_t`/`DEF_DCONF`.
- Sub-module `p_sat_add`: PREC-bit signed saturating adder with overflow/underflow outputs; reusable by other accumulating stages.

## Test plan
- PREC=8, BEATS=4: beats +3, -1, +5 (last), thresh 6 → `out_sum` 7, `out_act` 1, `out_beats` 3, `out_sat` 0, `out_valid` at cycle after last.
- Beats +100, +100 (last), thresh 0 → `out_sum` 127, `out_sat` 1; beats -100, -100 → `out_sum` -128, `out_sat` 1, `out_act` 0.
- `out_ready` held low 5 cycles → `out_valid` and outputs stable, `in_ready` 0, offered beats not consumed; `out_ready` high → IDLE next cycle.
- Five beats before `in_last` with BEATS=4 → `out_err` 1, `out_beats` 4, sum still accumulated.
- Single beat -2 with `in_last`, thresh -2 → `out_act` 1 (equality), `out_beats` 1; `in_udf` set on a beat → `out_sat` 1.
- Reset pulsed after 2 beats → outputs zero, next frame of +4 (last) gives `out_sum` 4 with no residue.

Source files
------------

// File: rtl/p_bool_neuron_acc_pkg.sv
// Shared perceptron datapath types: FSM state enum, datapath configuration
// and the signed saturation limits that every accumulating stage agrees on.
package p_bool_neuron_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } bacc_state_t;

    typedef struct packed {
        logic [7:0] prec;
    } dconf_t;

    localparam dconf_t DEF_DCONF = '{prec: 8'd16};

    // Limits are returned 64 bits wide and truncated by the caller to its PREC.
    function automatic logic signed [63:0] satMax(input int prec);
        return (64'sd1 <<< (prec - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] satMin(input int prec);
        return -(64'sd1 <<< (prec - 1));
    endfunction

endpackage

// File: rtl/p_sat_add.sv
// W-bit signed saturating adder; flags which rail the result was clamped to
// so accumulating stages can fold it into their own sticky saturation bit.
module p_sat_add
    import p_bool_neuron_acc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                ovf_o,
    output logic                udf_o
);

    localparam logic signed [63:0] MAX_WIDE = satMax(W);
    localparam logic signed [63:0] MIN_WIDE = satMin(W);
    localparam logic signed [W-1:0] MAX_VAL = MAX_WIDE[W-1:0];
    localparam logic signed [W-1:0] MIN_VAL = MIN_WIDE[W-1:0];

    logic signed [W:0] wide;

    // One guard bit is enough: disagreement between the top two bits means
    // the true sum left the W-bit range.
    always_comb begin
        wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
        ovf_o = ~wide[W] & wide[W-1];
        udf_o = wide[W] & ~wide[W-1];
        if (ovf_o) begin
            sum_o = MAX_VAL;
        end else if (udf_o) begin
            sum_o = MIN_VAL;
        end else begin
            sum_o = wide[W-1:0];
        end
    end

endmodule

// File: rtl/p_bool_neuron_acc.sv
// Frame accumulator plus binary activation behind p_bool_acc: sums signed
// popcount beats with saturation and presents act/sum over valid/ready.
module p_bool_neuron_acc
    import p_bool_neuron_acc_pkg::*;
#(
    parameter int     IN    = 8,
    parameter dconf_t CONF  = DEF_DCONF,
    parameter int     PREC  = int'(CONF.prec),
    parameter int     BEATS = 4,
    parameter int     CW    = $clog2(BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [PREC-1:0] in_sum,
    input  logic                   in_ovf,
    input  logic                   in_udf,
    input  logic                   in_last,
    input  logic signed [PREC-1:0] thresh,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_act,
    output logic signed [PREC-1:0] out_sum,
    output logic                   out_sat,
    output logic                   out_err,
    output logic [CW-1:0]          out_beats
);

    if (PREC < $clog2(IN + 1) + 1) begin : g_prec_check
        $error("PREC too narrow to carry one IN-bit partial sum");
    end

    bacc_state_t state_q, state_d;
    logic signed [PREC-1:0] acc_q, acc_d;
    logic signed [PREC-1:0] thr_q, thr_d;
    logic [CW-1:0]          beats_q, beats_d;
    logic                   sat_q, sat_d;
    logic                   err_q, err_d;
    logic                   act_q, act_d;

    logic signed [PREC-1:0] addA;
    logic signed [PREC-1:0] addSum;
    logic                   addOvf;
    logic                   addUdf;
    logic                   accept;

    // A new frame starts from zero rather than from the stale held sum.
    assign addA = (state_q == IDLE) ? '0 : acc_q;

    p_sat_add #(
        .W(PREC)
    ) u_sat_add (
        .a_i  (addA),
        .b_i  (in_sum),
        .sum_o(addSum),
        .ovf_o(addOvf),
        .udf_o(addUdf)
    );

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            thr_q   <= '0;
            beats_q <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            thr_q   <= thr_d;
            beats_q <= beats_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        thr_d   = thr_q;
        beats_d = beats_q;
        sat_d   = sat_q;
        err_d   = err_q;
        act_d   = act_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = addSum;
                    thr_d   = thresh;
                    beats_d = CW'(1);
                    sat_d   = addOvf | addUdf | in_ovf | in_udf;
                    err_d   = 1'b0;
                    if (in_last) begin
                        state_d = HOLD;
                        act_d   = (addSum >= thresh);
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = addSum;
                    sat_d = sat_q | addOvf | addUdf | in_ovf | in_udf;
                    // Beat count pins at BEATS so out_beats never wraps on overrun.
                    if (beats_q == CW'(BEATS)) begin
                        err_d = 1'b1;
                    end else begin
                        beats_d = beats_q + CW'(1);
                    end
                    if (in_last) begin
                        state_d = HOLD;
                        act_d   = (addSum >= thr_q);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = (state_q == HOLD);
    assign out_act   = act_q;
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;
    assign out_beats = beats_q;

endmodule
